// File: rtl/move_sequencer_if.sv
// Move handshake bundle between the move sequencer and its consumer.
// The sequencer drives a move (aggressor/victim squares) with valid.
// The consumer accepts it with ready.
interface move_sequencer_if;
  logic       move_valid;
  logic       move_ready;
  logic [5:0] move_from;
  logic [5:0] move_to;

  modport master (
    output move_valid,
    output move_from,
    output move_to,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_from,
    input  move_to,
    output move_ready
  );
endinterface

// File: rtl/move_sequencer.sv
// Move sequencer.
//
// Drives the 64-square array through find-victim / find-aggressor passes.
// For each move found, it offers (aggressor -> victim) on the move handshake.
// An argmax over the 3-bit square priorities picks the square.
// Ties go to the lowest index, and all-zero means "none".
//
// Optional build macro: MOVESEQ_PIPE_EN.
// When defined, the argmax result and the king OR are registered.
// FV and FA then spend one settle cycle before deciding.
// The default build decides in the same cycle from the combinational argmax.
//
// All outputs decode from registered state only.
module move_sequencer (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    wtm,
  input  logic [191:0]            prio_flat,
  input  logic [63:0]             king_flat,
  output logic [2:0]              state_mode,
  output logic [1:0]              mask_mode,
  output logic [63:0]             ss1,
  output logic                    ss2,
  output logic                    busy,
  output logic                    done,
  output logic                    illegal,
  move_sequencer_if.master        mv
);

  // Square command codes
  localparam logic [2:0] SM_FV      = 3'd1;
  localparam logic [2:0] SM_FA      = 3'd2;
  // Mask command codes
  localparam logic [1:0] MM_NONE    = 2'd0;
  localparam logic [1:0] MM_EAV_EAA = 2'd1;
  localparam logic [1:0] MM_DV_EAA  = 2'd2;
  localparam logic [1:0] MM_DA      = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_FV    = 3'd2;
  localparam logic [2:0] S_FA    = 3'd3;
  localparam logic [2:0] S_OFFER = 3'd4;
  localparam logic [2:0] S_DV    = 3'd5;
  localparam logic [2:0] S_DA    = 3'd6;

  logic [2:0] state_q, state_d;
  logic [5:0] from_q, from_d;
  logic [5:0] to_q, to_d;
  logic       done_q, done_d;
  logic       illegal_q, illegal_d;

  logic [2:0] best_val;
  logic [5:0] best_idx;
  logic       king_any;

  logic       dec_ok;
  logic       dec_none;
  logic       dec_king;
  logic [5:0] dec_idx;

  // Side to move goes straight to the squares; the sequencer itself ignores it.
  logic unused_wtm;
  assign unused_wtm = wtm;

  // Argmax over square priorities; strict compare keeps the lowest index on ties
  always_comb begin
    best_val = '0;
    best_idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (prio_flat[3*i +: 3] > best_val) begin
        best_val = prio_flat[3*i +: 3];
        best_idx = 6'(i);
      end
    end
  end

  assign king_any = |king_flat;

`ifdef MOVESEQ_PIPE_EN
  logic [2:0] am_val_q;
  logic [5:0] am_idx_q;
  logic       king_q;
  logic       settle_q, settle_d;

  // Registered argmax and king OR, sampled every cycle
  always_ff @(posedge clk) begin
    am_val_q <= best_val;
    am_idx_q <= best_idx;
    king_q   <= king_any;
  end

  // First FV/FA cycle only settles; the second one decides
  assign settle_d = ((state_q == S_FV) || (state_q == S_FA)) && !settle_q;

  // Settle phase flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) settle_q <= 1'b0;
    else        settle_q <= settle_d;
  end

  assign dec_ok   = settle_q;
  assign dec_none = (am_val_q == 3'd0);
  assign dec_king = king_q;
  assign dec_idx  = am_idx_q;
`else
  assign dec_ok   = 1'b1;
  assign dec_none = (best_val == 3'd0);
  assign dec_king = king_any;
  assign dec_idx  = best_idx;
`endif

  // Next-state logic for the sequencing FSM
  always_comb begin
    state_d   = state_q;
    from_d    = from_q;
    to_d      = to_q;
    done_d    = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_INIT;
          illegal_d = 1'b0;
        end
      end
      S_INIT: state_d = S_FV;
      S_FV: begin
        if (dec_ok) begin
          if (dec_king) begin
            illegal_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else if (dec_none) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            to_d    = dec_idx;
            state_d = S_FA;
          end
        end
      end
      S_FA: begin
        if (dec_ok) begin
          if (dec_none) begin
            state_d = S_DV;
          end else begin
            from_d  = dec_idx;
            state_d = S_OFFER;
          end
        end
      end
      S_OFFER: begin
        if (mv.move_ready) state_d = S_DA;
      end
      S_DA:    state_d = S_FA;
      S_DV:    state_d = S_FV;
      default: state_d = S_IDLE;
    endcase
  end

  // State and move registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      from_q    <= '0;
      to_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      from_q    <= from_d;
      to_q      <= to_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Square/mask command decode from the registered state
  always_comb begin
    state_mode = SM_FV;
    mask_mode  = MM_NONE;
    ss1        = '0;
    case (state_q)
      S_INIT:  mask_mode = MM_EAV_EAA;
      S_FA: begin
        state_mode = SM_FA;
        ss1        = 64'd1 << to_q;
      end
      S_OFFER: state_mode = SM_FA;
      S_DA: begin
        state_mode = SM_FA;
        mask_mode  = MM_DA;
        ss1        = 64'd1 << from_q;
      end
      S_DV: begin
        mask_mode = MM_DV_EAA;
        ss1       = 64'd1 << to_q;
      end
      default: ;
    endcase
  end

  assign ss2           = 1'b0;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign illegal       = illegal_q;
  assign mv.move_valid = (state_q == S_OFFER);
  assign mv.move_from  = from_q;
  assign mv.move_to    = to_q;

endmodule
